// File: rtl/instruction_memory_loader.sv
// Instruction memory with a power-up clear pass, a streaming load phase and a
// registered fetch port. The memory can only be reprogrammed by a reset, which
// always restarts the full clear sequence before new words are accepted.
module instruction_memory_loader #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              mem_ready
);

  localparam int unsigned       Depth    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    StClear,
    StLoad,
    StRun
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]   load_ptr_q, load_ptr_d;
  logic [ADDR_W:0]     load_count_q, load_count_d;
  logic [DATA_W-1:0]   inst_q, inst_d;
  logic                inst_valid_q, inst_valid_d;

  logic                load_accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [DATA_W-1:0]   mem [Depth];

  // State register and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StClear;
      clr_ptr_q    <= '0;
      load_ptr_q   <= '0;
      load_count_q <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Next-state logic: CLEAR walks every entry once, LOAD ends on last word or full memory
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: begin
        if (clr_ptr_q == LastAddr) state_d = StLoad;
      end
      StLoad: begin
        if (load_valid && (load_last || load_ptr_q == LastAddr)) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // State-decoded outputs and memory write port selection
  always_comb begin
    load_ready  = 1'b0;
    mem_ready   = 1'b0;
    load_accept = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = clr_ptr_q;
    mem_wdata   = NOP_WORD;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
      end
      StLoad: begin
        load_ready  = 1'b1;
        load_accept = load_valid;
        mem_we      = load_valid;
        mem_waddr   = load_ptr_q;
        mem_wdata   = load_data;
      end
      StRun: begin
        mem_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Pointer, counter and fetch register next values
  always_comb begin
    clr_ptr_d    = clr_ptr_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;

    if (state_q == StClear) clr_ptr_d = clr_ptr_q + ADDR_W'(1);

    if (load_accept) begin
      load_count_d = load_count_q + (ADDR_W + 1)'(1);
      // The final entry ends the load phase, so the pointer parks instead of wrapping
      if (load_ptr_q != LastAddr) load_ptr_d = load_ptr_q + ADDR_W'(1);
    end

    if (state_q == StRun) begin
      if (stall) begin
        inst_valid_d = inst_valid_q;
      end else if (fetch_en) begin
        inst_d       = mem[addr];
        inst_valid_d = 1'b1;
      end
    end
  end

  // Single write port shared by the clear pass and the load stream
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign load_count = load_count_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: doc/instruction_memory_loader.md
INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 10, address width; DEPTH = 2^ADDR_W entries.
REQ-003 SHALL have parameter NOP_WORD, default all-zero (DATA_W bits), fill value written during clear.
REQ-004 SHALL have port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low; rst=0 sampled at a rising edge resets the block.
REQ-006 SHALL have port load_valid  input  1  load word present on load_data.
REQ-007 SHALL have port load_data  input  DATA_W  instruction word to load.
REQ-008 SHALL have port load_last  input  1  marks the final load word; qualified by load_valid.
REQ-009 SHALL have port load_ready  output  1  block accepts load words.
REQ-010 SHALL have port load_count  output  ADDR_W+1  number of words accepted since reset.
REQ-011 SHALL have port fetch_en  input  1  fetch request.
REQ-012 SHALL have port stall  input  1  freeze fetch output.
REQ-013 SHALL have port addr  input  ADDR_W  fetch address.
REQ-014 SHALL have port inst  output  DATA_W  fetched instruction, registered.
REQ-015 SHALL have port inst_valid  output  1  inst holds a valid fetch result.
REQ-016 SHALL have port mem_ready  output  1  memory loaded, fetch enabled.

Function
REQ-017 SHALL implement states CLEAR, LOAD, RUN; the reset state is CLEAR.
REQ-018 CLEAR SHALL write NOP_WORD to entry clr_ptr each cycle, clr_ptr 0 to DEPTH-1, one entry per cycle.
REQ-019 After writing entry DEPTH-1, the FSM SHALL enter LOAD on the next edge; CLEAR lasts exactly DEPTH cycles.
REQ-020 In LOAD, load_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 In LOAD, load_valid=1 SHALL write load_data to entry load_ptr, increment load_ptr and increment load_count.
REQ-022 In LOAD, load_valid=0 SHALL leave load_ptr, load_count and memory unchanged.
REQ-023 An accepted word with load_last=1 SHALL move the FSM to RUN on the same edge it is written.
REQ-024 An accepted word written to entry DEPTH-1 SHALL move the FSM to RUN whether or not load_last=1; load_count then equals DEPTH, and load_ptr does not wrap.
REQ-025 In RUN, mem_ready SHALL be 1; load_valid SHALL be ignored.
REQ-026 In RUN, fetch_en=1 and stall=0 SHALL register inst<=mem[addr] and inst_valid<=1; latency is one cycle.
REQ-027 In RUN, stall=1 SHALL hold inst and inst_valid regardless of fetch_en and addr.
REQ-028 In RUN, fetch_en=0 and stall=0 SHALL set inst_valid<=0 and hold inst.
REQ-029 In CLEAR and LOAD, fetch_en and stall SHALL be ignored, and inst_valid SHALL remain 0.
REQ-030 Memory SHALL be reprogrammable only via reset; no RUN->LOAD transition exists.

Reset
REQ-031 rst=0 at an edge SHALL set inst=0, inst_valid=0, load_ready=0, mem_ready=0, load_count=0, clr_ptr=0, load_ptr=0 and state=CLEAR.
REQ-032 Reset asserted in any state, including mid-CLEAR or mid-LOAD, SHALL restart the full clear sequence; prior contents are not retained.
REQ-033 While rst=0, all outputs SHALL hold their reset values.

Verification (DATA_W=16, ADDR_W=4, NOP_WORD=0)
REQ-034 Scenario: rst=0 for 3 cycles, then release -> load_ready=0 for 16 cycles, then load_ready=1 on cycle 17.
REQ-035 Scenario: load 0x1111, 0x2222, 0x3333 with load_last on the third word -> mem_ready=1 next cycle and load_count=3; fetch addr 1 -> inst=0x2222, inst_valid=1 one cycle later; fetch addr 5 -> inst=0x0000.
REQ-036 Scenario: fetch addr 0, then stall=1 for 2 cycles with addr=2 -> inst stays 0x1111 and inst_valid stays 1; after stall=0, inst=0x3333.
REQ-037 Scenario: load_valid toggles 1,0,0,1 with load_last on the second accepted word -> load_count=2, and words land at addr 0 and 1.
REQ-038 Scenario: load 16 words without load_last -> RUN after the 16th word, load_count=16; a 17th load_valid is ignored and entry 15 is unchanged.
REQ-039 Scenario: reset after 2 words loaded, then clear and load_last on the first word 0xABCD -> fetch addr 1 returns 0x0000 and addr 0 returns 0xABCD.
